// File: rtl/anton_neopixel_registers_mc.sv
// anton_neopixel_registers_mc
//
// Register file and pixel frame buffer for CHANNELS independent NeoPixel
// strips. It sits between the 8-bit bus bridge and one stream engine per
// channel.
//
// Ports
//   busClk, busRst      clock and asynchronous active-high reset
//   busAddr             byte address; [15]=0 pixel window, [15]=1 registers
//   busDataIn           write data
//   busWrite, busRead   one-cycle access strobes
//   busDataOut          registered read data (1-cycle latency, held between reads)
//   irq                 registered OR of enabled pending interrupts, all channels
//   pixelIndexComb      per-channel RAM read index (slice n = channel n)
//   pixelVal            per-channel RAM read data (registered read)
//   streamSyncOf, syncStart, state, initSlowDone
//                       per-channel engine events and state
//   regMax              per-channel 13-bit max register
//   regCtrlInit/Limit/Run/Loop/32bit, initSlow
//                       per-channel control outputs
//
// Register map (per channel, channel = busAddr[7:4], offset = busAddr[3:0])
//   0 MAX_LO [7:0]   1 MAX_HI [4:0]   2 CTRL {32bit,loop,run,limit,init}
//   3 STATUS {state} (read-only)      4 IRQ_STATUS {initDone,frameDone} W1C
//   5 IRQ_ENABLE [1:0]

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 299
`endif

module anton_neopixel_registers_mc #(
    parameter int CHANNELS    = 2,
    parameter int BUFFER_END  = `BUFFER_END_DEFAULT,
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1),
    localparam int CH_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            busClk,
    input  logic                            busRst,
    input  logic [15:0]                     busAddr,
    input  logic [7:0]                      busDataIn,
    input  logic                            busWrite,
    input  logic                            busRead,
    output logic [7:0]                      busDataOut,
    output logic                            irq,
    input  logic [CHANNELS*BUFFER_BITS-1:0] pixelIndexComb,
    output logic [CHANNELS*8-1:0]           pixelVal,
    input  logic [CHANNELS-1:0]             streamSyncOf,
    input  logic [CHANNELS-1:0]             syncStart,
    input  logic [CHANNELS-1:0]             state,
    input  logic [CHANNELS-1:0]             initSlowDone,
    output logic [CHANNELS*13-1:0]          regMax,
    output logic [CHANNELS-1:0]             regCtrlInit,
    output logic [CHANNELS-1:0]             regCtrlLimit,
    output logic [CHANNELS-1:0]             regCtrlRun,
    output logic [CHANNELS-1:0]             regCtrlLoop,
    output logic [CHANNELS-1:0]             regCtrl32bit,
    output logic [CHANNELS-1:0]             initSlow
);

    localparam logic [BUFFER_BITS-1:0] LAST_BYTE = BUFFER_BITS'(BUFFER_END);
    localparam logic [12:0]            MAX_RST   = 13'(BUFFER_END);
    localparam logic [4:0]             CH_COUNT  = 5'(CHANNELS);

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic [3:0]             reg_ch;
    logic [3:0]             reg_off;
    logic [CH_BITS-1:0]     pix_ch;
    logic [BUFFER_BITS-1:0] pix_byte;
    logic                   pix_ok;
    logic [CHANNELS-1:0]    reg_hit;
    logic                   unused_addr;

    assign reg_ch   = busAddr[7:4];
    assign reg_off  = busAddr[3:0];
    assign pix_ch   = busAddr[BUFFER_BITS+CH_BITS-1:BUFFER_BITS];
    assign pix_byte = busAddr[BUFFER_BITS-1:0];
    assign pix_ok   = ({{(5-CH_BITS){1'b0}}, pix_ch} < CH_COUNT) && (pix_byte <= LAST_BYTE);
    // Address bits above the decoded fields alias onto the same locations.
    assign unused_addr = ^busAddr;

    // A channel number at or beyond CHANNELS matches no reg_hit bit, so such
    // writes fall away without a separate range check.
    always_comb begin
        reg_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            reg_hit[c] = busWrite && busAddr[15] && (reg_ch == 4'(c));
        end
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [CHANNELS*13-1:0] max_q, max_d;
    logic [CHANNELS-1:0]    init_q, init_d;
    logic [CHANNELS-1:0]    limit_q, limit_d;
    logic [CHANNELS-1:0]    run_q, run_d;
    logic [CHANNELS-1:0]    loop_q, loop_d;
    logic [CHANNELS-1:0]    b32_q, b32_d;
    logic [CHANNELS-1:0]    init_slow_q, init_slow_d;
    logic [CHANNELS*2-1:0]  irq_stat_q, irq_stat_d;
    logic [CHANNELS*2-1:0]  irq_en_q, irq_en_d;
    logic                   irq_q, irq_d;
    logic [7:0]             bus_data_q, bus_data_d;

    logic                   wr_pend_q, wr_pend_d;
    logic [CH_BITS-1:0]     wr_ch_q, wr_ch_d;
    logic [BUFFER_BITS-1:0] wr_byte_q, wr_byte_d;
    logic [7:0]             wr_data_q, wr_data_d;

    logic [CHANNELS*8-1:0]  pixel_val_q, pixel_val_d;
    logic [7:0]             mem [CHANNELS][BUFFER_END+1];

    // ---------------------------------------------------------------
    // Pixel write capture: the RAM is written one edge after busWrite.
    // ---------------------------------------------------------------
    always_comb begin
        wr_pend_d = busWrite && !busAddr[15] && pix_ok;
        wr_ch_d   = pix_ch;
        wr_byte_d = pix_byte;
        wr_data_d = busDataIn;
    end

    // ---------------------------------------------------------------
    // Per-channel control and interrupt registers. Later assignments in
    // each iteration take priority over earlier ones.
    // ---------------------------------------------------------------
    always_comb begin
        max_d       = max_q;
        init_d      = init_q;
        limit_d     = limit_q;
        run_d       = run_q;
        loop_d      = loop_q;
        b32_d       = b32_q;
        init_slow_d = init_slow_q;
        irq_stat_d  = irq_stat_q;
        irq_en_d    = irq_en_q;

        for (int c = 0; c < CHANNELS; c++) begin
            if (streamSyncOf[c]) begin
                run_d[c] = loop_q[c];
            end
            if (syncStart[c]) begin
                run_d[c] = 1'b1;
            end
            if (initSlowDone[c]) begin
                init_d[c]      = 1'b0;
                init_slow_d[c] = 1'b0;
            end
            // init stays high until the engine reports completion, so the
            // completion edge must not re-arm initSlow or it would never drop.
            if (init_q[c]) begin
                limit_d[c] = 1'b0;
                run_d[c]   = 1'b0;
                loop_d[c]  = 1'b0;
                b32_d[c]   = 1'b0;
                if (!initSlowDone[c]) begin
                    init_slow_d[c] = 1'b1;
                end
            end

            if (reg_hit[c]) begin
                case (reg_off)
                    4'd0: max_d[c*13 +: 8] = busDataIn;
                    4'd1: max_d[c*13+8 +: 5] = busDataIn[4:0];
                    4'd2: begin
                        init_d[c] = busDataIn[0];
                        run_d[c]  = busDataIn[2];
                        loop_d[c] = busDataIn[3];
                        // Frame geometry is frozen while the strip is running.
                        if (!run_q[c]) begin
                            limit_d[c] = busDataIn[1];
                            b32_d[c]   = busDataIn[4];
                        end
                    end
                    4'd4: irq_stat_d[c*2 +: 2] = irq_stat_q[c*2 +: 2] & ~busDataIn[1:0];
                    4'd5: irq_en_d[c*2 +: 2] = busDataIn[1:0];
                    default: ;
                endcase
            end

            // A hardware event on the same edge as a W1C clear still lands.
            irq_stat_d[c*2 +: 2] = irq_stat_d[c*2 +: 2] | {initSlowDone[c], streamSyncOf[c]};
        end
    end

    always_comb begin
        irq_d = |(irq_stat_q & irq_en_q);
    end

    // ---------------------------------------------------------------
    // Register read mux; the pixel window is write-only and reads 0.
    // ---------------------------------------------------------------
    always_comb begin
        bus_data_d = bus_data_q;
        if (busRead) begin
            bus_data_d = 8'h00;
            if (busAddr[15]) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (reg_ch == 4'(c)) begin
                        case (reg_off)
                            4'd0:    bus_data_d = max_q[c*13 +: 8];
                            4'd1:    bus_data_d = {3'b000, max_q[c*13+8 +: 5]};
                            4'd2:    bus_data_d = {3'b000, b32_q[c], loop_q[c], run_q[c],
                                                   limit_q[c], init_q[c]};
                            4'd3:    bus_data_d = {7'd0, state[c]};
                            4'd4:    bus_data_d = {6'd0, irq_stat_q[c*2 +: 2]};
                            4'd5:    bus_data_d = {6'd0, irq_en_q[c*2 +: 2]};
                            default: bus_data_d = 8'h00;
                        endcase
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Pixel RAM read port (synchronous read, old data on a same-edge write)
    // ---------------------------------------------------------------
    always_comb begin
        pixel_val_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (pixelIndexComb[c*BUFFER_BITS +: BUFFER_BITS] <= LAST_BYTE) begin
                pixel_val_d[c*8 +: 8] = mem[c][pixelIndexComb[c*BUFFER_BITS +: BUFFER_BITS]];
            end
        end
    end

    // ---------------------------------------------------------------
    // Sequential
    // ---------------------------------------------------------------
    always_ff @(posedge busClk or posedge busRst) begin
        if (busRst) begin
            max_q       <= {CHANNELS{MAX_RST}};
            init_q      <= '0;
            limit_q     <= '0;
            run_q       <= '0;
            loop_q      <= '0;
            b32_q       <= '0;
            init_slow_q <= '0;
            irq_stat_q  <= '0;
            irq_en_q    <= '0;
            irq_q       <= 1'b0;
            bus_data_q  <= 8'h00;
            wr_pend_q   <= 1'b0;
            wr_ch_q     <= '0;
            wr_byte_q   <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            max_q       <= max_d;
            init_q      <= init_d;
            limit_q     <= limit_d;
            run_q       <= run_d;
            loop_q      <= loop_d;
            b32_q       <= b32_d;
            init_slow_q <= init_slow_d;
            irq_stat_q  <= irq_stat_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            bus_data_q  <= bus_data_d;
            wr_pend_q   <= wr_pend_d;
            wr_ch_q     <= wr_ch_d;
            wr_byte_q   <= wr_byte_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // RAM contents and its read register are deliberately not reset.
    always_ff @(posedge busClk) begin
        if (wr_pend_q) begin
            mem[wr_ch_q][wr_byte_q] <= wr_data_q;
        end
        pixel_val_q <= pixel_val_d;
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign busDataOut   = bus_data_q;
    assign irq          = irq_q;
    assign pixelVal     = pixel_val_q;
    assign regMax       = max_q;
    assign regCtrlInit  = init_q;
    assign regCtrlLimit = limit_q;
    assign regCtrlRun   = run_q;
    assign regCtrlLoop  = loop_q;
    assign regCtrl32bit = b32_q;
    assign initSlow     = init_slow_q;

endmodule
